// File: rtl/mem_bus_master.sv
// mem_bus_master: turns 16/32-bit CPU load/store requests into one or two
// halfword phases on a 16-bit synchronous memory bus.
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort a phase after 255
// consecutive bus_ready=0 cycles and answer with resp_err=1.
module mem_bus_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] bus_addr,
  output logic [15:0] bus_write,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [15:0] bus_read,
  input  logic        bus_ready
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned TMO_W  = 8;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ISS = 3'd1,
    ST_RD_CAP = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic                phase_q, phase_d;   // 0 = LO halfword, 1 = HI halfword
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                wide_q, wide_d;
  logic [HALF_W-1:0]   lo_q, lo_d;
  logic [HALF_W-1:0]   hi_q, hi_d;
  logic                phase_done;
  logic                tmo_hit;
`ifdef MEM_BUS_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                resp_err_q, resp_err_d;
`endif

  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [HALF_W-1:0]   bus_write_q, bus_write_d;
  logic                bus_we_q, bus_we_d;
  logic                bus_re_q, bus_re_d;
  logic [ADDR_W-1:0]   phase_addr;

  // State, request latches and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      wide_q       <= 1'b0;
      lo_q         <= '0;
      hi_q         <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      tmo_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      bus_addr_q   <= '0;
      bus_write_q  <= '0;
      bus_we_q     <= 1'b0;
      bus_re_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      wide_q       <= wide_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
`ifdef MEM_BUS_TIMEOUT_EN
      tmo_q        <= tmo_d;
      resp_err_q   <= resp_err_d;
`endif
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      bus_addr_q   <= bus_addr_d;
      bus_write_q  <= bus_write_d;
      bus_we_q     <= bus_we_d;
      bus_re_q     <= bus_re_d;
    end
  end

  // Next state, halfword phase sequencing, read capture and wait timeout
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    wide_d     = wide_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    phase_done = 1'b0;
    tmo_hit    = 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
    tmo_d      = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          wide_d  = req_wide;
          phase_d = 1'b0;
          lo_d    = '0;
          hi_d    = '0;
          state_d = req_write ? ST_WR : ST_RD_ISS;
        end
      end
      ST_RD_ISS: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        if (bus_ready) begin
          if (phase_q) hi_d = bus_read;
          else         lo_d = bus_read;
          phase_done = 1'b1;
        end
      end
      ST_WR: begin
        if (bus_ready) phase_done = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        phase_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 1'b0;
      end
    endcase

    // A completed LO phase of a wide access re-enters the same kind of phase as HI
    if (phase_done) begin
      if (wide_q && !phase_q) begin
        phase_d = 1'b1;
        state_d = write_q ? ST_WR : ST_RD_ISS;
      end else begin
        state_d = ST_RESP;
      end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    // Count consecutive stalled wait cycles; the 255th one abandons the access
    if (((state_q == ST_RD_CAP) || (state_q == ST_WR)) && !bus_ready) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (tmo_d == {TMO_W{1'b1}}) begin
        tmo_hit = 1'b1;
        tmo_d   = '0;
        state_d = ST_RESP;
      end
    end
`endif
  end

  // Output values for the cycle after the edge, decoded from the next state
  always_comb begin
    phase_addr   = phase_d ? (addr_d + ADDR_W'(1)) : addr_d;
    req_ready_d  = (state_d == ST_IDLE);
    bus_re_d     = (state_d == ST_RD_ISS) || (state_d == ST_RD_CAP);
    bus_we_d     = (state_d == ST_WR);
    bus_addr_d   = (bus_re_d || bus_we_d) ? phase_addr : '0;
    bus_write_d  = bus_we_d ? (phase_d ? wdata_d[31:16] : wdata_d[15:0]) : '0;
    resp_valid_d = (state_d == ST_RESP);
    resp_rdata_d = resp_rdata_q;
    if (state_d == ST_RESP) begin
      resp_rdata_d = (write_d || tmo_hit) ? '0
                   : {(wide_d ? hi_d : HALF_W'(0)), lo_d};
    end
`ifdef MEM_BUS_TIMEOUT_EN
    resp_err_d   = tmo_hit;
`endif
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign bus_addr   = bus_addr_q;
  assign bus_write  = bus_write_q;
  assign bus_we     = bus_we_q;
  assign bus_re     = bus_re_q;
`ifdef MEM_BUS_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: a reactive memory slave with per-phase wait
// states, and a reference memory giving expected data, writes and latency.
// Honours MEM_BUS_TIMEOUT_EN the same way the design does.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_wide = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] bus_addr;
  logic [15:0] bus_write;
  logic        bus_we;
  logic        bus_re;
  logic [15:0] bus_read = '0;
  logic        bus_ready = 1'b0;

  always #5 clk = ~clk;

  mem_bus_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_addr(bus_addr), .bus_write(bus_write), .bus_we(bus_we),
    .bus_re(bus_re), .bus_read(bus_read), .bus_ready(bus_ready)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
  } wr_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem     [logic [31:0]];
  logic [15:0] ref_mem [logic [31:0]];
  wr_t         wr_log[$];

  // slave configuration and state
  logic [31:0] t_addr = '0;
  int          w_lo = 0, w_hi = 0;
  bit          stuck = 1'b0;
  bit          mon_en = 1'b0;
  int          re_cycles = 0, we_cycles = 0;
  int          j = 0;
  logic        prev_act = 1'b0, prev_we = 1'b0, prev_rdy = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_wdata = '0;

  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  // Synchronous read port: data appears one cycle after the address
  always @(posedge clk) bus_read <= bus_re ? mem_rd(bus_addr) : 16'h0000;

  // Bus slave: protocol checks, wait-state generation and write capture
  always @(negedge clk) begin : slave
    logic act;
    int   w;
    wr_t  e;
    act = bus_re | bus_we;
    if (mon_en) begin
      n_checks++;
      if (bus_re === 1'b1 && bus_we === 1'b1) begin
        n_fail++; $display("FAIL strobe_excl: bus_re=%b bus_we=%b, required not both 1", bus_re, bus_we);
      end
      if (bus_we !== 1'b1) begin
        n_checks++;
        if (bus_write !== 16'h0) begin
          n_fail++; $display("FAIL idle_wdata: bus_write=%h, required 0000", bus_write);
        end
      end
      if (!act) begin
        n_checks++;
        if (bus_addr !== 32'h0) begin
          n_fail++; $display("FAIL idle_addr: bus_addr=%h, required 00000000", bus_addr);
        end
      end
      if (prev_act && !prev_rdy && !stuck && !rst) begin
        n_checks++;
        if (act !== 1'b1 || bus_we !== prev_we || bus_addr !== prev_addr || bus_write !== prev_wdata) begin
          n_fail++;
          $display("FAIL bus_hold: act=%b we=%b addr=%h wdata=%h, required act=1 we=%b addr=%h wdata=%h",
                   act, bus_we, bus_addr, bus_write, prev_we, prev_addr, prev_wdata);
        end
      end
      if (bus_re === 1'b1) re_cycles++;
      if (bus_we === 1'b1) we_cycles++;
    end
    if (act && (!prev_act || bus_addr !== prev_addr || bus_we !== prev_we)) j = 0;
    else if (act) j++;
    w = (bus_addr === t_addr) ? w_lo : w_hi;
    if (stuck || !act || !mon_en) bus_ready = 1'b0;
    else                          bus_ready = bus_we ? (j >= w) : (j >= w + 1);
    if (bus_we === 1'b1 && bus_ready) begin
      mem[bus_addr] = bus_write;
      e.a = bus_addr;
      e.d = bus_write;
      wr_log.push_back(e);
    end
    prev_act   = rst ? 1'b0 : act;
    prev_we    = bus_we;
    prev_addr  = bus_addr;
    prev_wdata = bus_write;
    prev_rdy   = bus_ready;
  end

  // One complete transaction, checked against the reference memory
  task automatic do_txn(input bit wr, input bit wd, input logic [31:0] a,
                        input logic [31:0] wdata, input int wlo, input int whi,
                        input string name);
    int          exp_lat, lat, exp_re, exp_we;
    logic [31:0] exp_rdata;
    wr_t         exp_w[$];
    wr_t         e;
    exp_lat = wr ? (wd ? 3 + wlo + whi : 2 + wlo) : (wd ? 5 + wlo + whi : 3 + wlo);
    exp_re  = wr ? 0 : (2 + wlo + (wd ? 2 + whi : 0));
    exp_we  = wr ? (1 + wlo + (wd ? 1 + whi : 0)) : 0;
    if (wr) begin
      e.a = a; e.d = wdata[15:0]; exp_w.push_back(e); ref_mem[a] = wdata[15:0];
      if (wd) begin
        e.a = a + 32'd1; e.d = wdata[31:16]; exp_w.push_back(e); ref_mem[a + 32'd1] = wdata[31:16];
      end
      exp_rdata = 32'h0;
    end else begin
      exp_rdata = {(wd ? ref_rd(a + 32'd1) : 16'h0000), ref_rd(a)};
    end

    @(negedge clk);
    t_addr = a; w_lo = wlo; w_hi = whi;
    wr_log.delete(); re_cycles = 0; we_cycles = 0;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_idle: req_ready=%b, required 1", name, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_wide = wd; req_addr = a; req_wdata = wdata;
    @(posedge clk);
    #1;
    // noise on the request port while busy must be ignored
    req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom); req_wide = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    for (int n = 1; n <= 100 && lat == 0; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = n;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d cycles, required %0d (0 = none)", name, lat, exp_lat);
    end
    n_checks++;
    if (resp_rdata !== exp_rdata || resp_err !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s resp: rdata=%h err=%b ready=%b, required rdata=%h err=0 ready=0",
               name, resp_rdata, resp_err, req_ready, exp_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL %s after_resp: valid=%b ready=%b rdata=%h, required valid=0 ready=1 rdata=%h",
               name, resp_valid, req_ready, resp_rdata, exp_rdata);
    end
    n_checks++;
    if (re_cycles != exp_re || we_cycles != exp_we) begin
      n_fail++;
      $display("FAIL %s strobe_cycles: re=%0d we=%0d, required re=%0d we=%0d",
               name, re_cycles, we_cycles, exp_re, exp_we);
    end
    n_checks++;
    if (wr_log.size() != exp_w.size()) begin
      n_fail++; $display("FAIL %s write_count: got %0d, required %0d", name, wr_log.size(), exp_w.size());
    end else begin
      foreach (exp_w[k]) begin
        n_checks++;
        if (wr_log[k] !== exp_w[k]) begin
          n_fail++;
          $display("FAIL %s write%0d: addr=%h data=%h, required addr=%h data=%h",
                   name, k, wr_log[k].a, wr_log[k].d, exp_w[k].a, exp_w[k].d);
        end
      end
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [15:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1; req_addr = 32'h1234_5678; req_write = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
        bus_addr !== 32'h0 || bus_write !== 16'h0 || bus_we !== 1'b0 || bus_re !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b addr=%h wdata=%h we=%b re=%b, required ready=1, rest 0",
               req_ready, resp_valid, resp_rdata, resp_err, bus_addr, bus_write, bus_we, bus_re);
    end
    req_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_narrow_store();
    do_txn(1'b1, 1'b0, 32'hD000_0010, 32'h0000_BEEF, 0, 0, "narrow_store");
  endtask

  task automatic test_wide_load();
    preload(32'h1000_0004, 16'h1234);
    preload(32'h1000_0005, 16'hABCD);
    do_txn(1'b0, 1'b1, 32'h1000_0004, 32'h0, 0, 0, "wide_load");
    do_txn(1'b0, 1'b0, 32'h1000_0005, 32'h0, 0, 0, "narrow_load");
  endtask

  task automatic test_wrap_store();
    do_txn(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h5555_AAAA, 0, 0, "wrap_store");
    do_txn(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1, 0, "wrap_load");
  endtask

  task automatic test_stall_load();
    preload(32'h0000_0040, 16'hC0DE);
    do_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 3, 0, "stall_load");
    do_txn(1'b1, 1'b1, 32'h0000_0041, 32'h9876_0FED, 2, 3, "stall_store");
  endtask

  task automatic test_reset_abort();
    int seen;
    preload(32'h0000_2000, 16'h1111);
    preload(32'h0000_2001, 16'h2222);
    @(negedge clk);
    t_addr = 32'h0000_2000; w_lo = 0; w_hi = 2;
    req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b1; req_addr = 32'h0000_2000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_re !== 1'b1 || bus_addr !== 32'h0000_2001) begin
      n_fail++; $display("FAIL abort_hi_phase: re=%b addr=%h, required re=1 addr=00002001", bus_re, bus_addr);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || bus_re !== 1'b0 || bus_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_idle: ready=%b valid=%b re=%b addr=%h, required ready=1 valid=0 re=0 addr=0",
               req_ready, resp_valid, bus_re, bus_addr);
    end
    #2 rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_no_resp: %0d resp_valid cycles, required 0", seen);
    end
    do_txn(1'b0, 1'b0, 32'h0000_2001, 32'h0, 1, 0, "after_abort");
  endtask

  task automatic test_timeout();
    int lat;
    int seen;
`ifdef MEM_BUS_TIMEOUT_EN
    // store stuck from its first wait cycle
    @(negedge clk);
    stuck = 1'b1; t_addr = 32'h0000_3000; wr_log.delete();
    req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1; req_addr = 32'h0000_3000; req_wdata = 32'h1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 400 && lat == 0; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) lat = n;
    end
    n_checks++;
    if (lat != 256 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL tmo_store: lat=%0d err=%b rdata=%h, required lat=256 err=1 rdata=0", lat, resp_err, resp_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || req_ready !== 1'b1 || wr_log.size() != 0) begin
      n_fail++;
      $display("FAIL tmo_store_after: valid=%b err=%b ready=%b writes=%0d, required 0 0 1 0",
               resp_valid, resp_err, req_ready, wr_log.size());
    end
    // wide load: previous nonzero data must not leak, HI phase skipped
    stuck = 1'b0;
    preload(32'h0000_3100, 16'h7777);
    do_txn(1'b0, 1'b0, 32'h0000_3100, 32'h0, 0, 0, "pre_tmo_load");
    @(negedge clk);
    stuck = 1'b1; t_addr = 32'h0000_3100; re_cycles = 0;
    req_valid = 1'b1; req_write = 1'b0; req_wide = 1'b1; req_addr = 32'h0000_3100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 400 && lat == 0; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) lat = n;
    end
    n_checks++;
    if (lat != 257 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || re_cycles != 256) begin
      n_fail++;
      $display("FAIL tmo_load: lat=%0d err=%b rdata=%h re_cycles=%0d, required lat=257 err=1 rdata=0 re_cycles=256",
               lat, resp_err, resp_rdata, re_cycles);
    end
    stuck = 1'b0;
`else
    lat = 0;
    @(negedge clk);
    stuck = 1'b1; t_addr = 32'h0000_3000;
    req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b0; req_addr = 32'h0000_3000; req_wdata = 32'h1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (resp_valid === 1'b1 || resp_err !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0 || bus_we !== 1'b1 || bus_addr !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL no_tmo_wait: resp/err cycles=%0d we=%b addr=%h, required 0 1 00003000", seen, bus_we, bus_addr);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || bus_we !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_tmo_reset: ready=%b we=%b valid=%b, required 1 0 0", req_ready, bus_we, resp_valid);
    end
    #2 rst = 1'b0;
    stuck = 1'b0;
`endif
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    logic [31:0] a;
    pool[0] = 32'h0000_0100; pool[1] = 32'h0000_0101; pool[2] = 32'h0000_0102;
    pool[3] = 32'hFFFF_FFFE; pool[4] = 32'hFFFF_FFFF; pool[5] = 32'h0000_0000;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
      do_txn(1'($urandom), 1'($urandom), a, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_narrow_store();
    test_wide_load();
    test_wrap_store();
    test_stall_load();
    test_reset_abort();
    test_timeout();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 The block SHALL use clk as its clock and rst as its reset; rst is synchronous and active-high.
REQ-002 Ports SHALL be, in order (name  direction  width  meaning):
 clk  in  1  clock
 rst  in  1  sync active-high reset
 req_valid  in  1  CPU request present
 req_ready  out  1  block accepts request (IDLE only)
 req_write  in  1  1=store, 0=load
 req_wide  in  1  1=32-bit (two halfwords), 0=16-bit
 req_addr  in  32  halfword address
 req_wdata  in  32  store data; [15:0] at addr, [31:16] at addr+1
 resp_valid  out  1  one-cycle completion pulse
 resp_rdata  out  32  load data, valid with resp_valid
 resp_err  out  1  timeout abort flag, valid with resp_valid
 bus_addr  out  32  memory bus address
 bus_write  out  16  memory bus write data
 bus_we  out  1  memory bus write strobe
 bus_re  out  1  memory bus read strobe
 bus_read  in  16  memory bus read data, synchronous, one cycle after address
 bus_ready  in  1  memory bus phase complete when high

Function
REQ-003 States SHALL be IDLE, RD_ISS, RD_CAP, WR, RESP, plus a 1-bit halfword phase (LO/HI).
REQ-004 req_ready SHALL be 1 only in IDLE; the request is accepted on the edge where req_valid && req_ready, latching addr, wdata, write and wide.
REQ-005 Accepted load -> RD_ISS, phase LO; accepted store -> WR, phase LO.
REQ-006 RD_ISS SHALL drive bus_re=1 and bus_addr=phase address for one cycle, then go to RD_CAP.
REQ-007 RD_CAP SHALL hold bus_re=1 and bus_addr; on bus_ready=1 it captures bus_read into the phase's halfword; it stays in RD_CAP while bus_ready=0.
REQ-008 WR SHALL drive bus_we=1, bus_addr and bus_write=phase halfword; it stays while bus_ready=0 and completes the phase on bus_ready=1.
REQ-009 After phase LO completes: if wide, phase<=HI and re-enter RD_ISS or WR; otherwise go to RESP. After phase HI completes, go to RESP.
REQ-010 Phase HI address SHALL be latched addr+1, mod 2^32; 0xFFFFFFFF wraps to 0x00000000.
REQ-011 RESP SHALL assert resp_valid for exactly one cycle, then go to IDLE; there is no response backpressure.
REQ-012 resp_rdata SHALL be {16'h0000, lo} for a narrow load, {hi, lo} for a wide load, and 0 for stores; it holds its value until the next RESP.
REQ-013 Latency from the accept edge to resp_valid with bus_ready=1 SHALL be: narrow store 2, wide store 3, narrow load 3, wide load 5 cycles.
REQ-014 Outside RD_ISS/RD_CAP/WR, bus_re, bus_we, bus_addr and bus_write SHALL be 0; bus_re and bus_we SHALL never be high together.
REQ-015 req_valid changes while the block is busy SHALL be ignored.

Reset
REQ-016 On rst, the state SHALL go to IDLE with phase LO and all outputs 0 except req_ready=1; timeout counter=0.
REQ-017 rst during a transaction SHALL abort it at that edge with no resp_valid; the aborted request is not retried.

Configuration
REQ-018 With MEM_BUS_TIMEOUT_EN defined, an 8-bit counter SHALL count consecutive bus_ready=0 cycles in RD_CAP or WR, and clear on phase completion or state change.
REQ-019 If that counter reaches 255, the block SHALL go to RESP with resp_err=1 and resp_rdata=0, skipping any remaining phase.
REQ-020 Without MEM_BUS_TIMEOUT_EN, the block SHALL wait on bus_ready indefinitely and resp_err SHALL be constant 0.

Verification
REQ-021 Narrow store addr=0xD0000010 wdata=0x0000BEEF, bus_ready=1 -> one cycle bus_we=1 with bus_addr=0xD0000010 and bus_write=0xBEEF; resp_valid 2 cycles after accept.
REQ-022 Wide load addr=0x10000004, memory [4]=0x1234 and [5]=0xABCD -> bus_re over two 2-cycle phases; resp_rdata=0xABCD1234 5 cycles after accept.
REQ-023 Wide store addr=0xFFFFFFFF wdata=0x5555AAAA -> writes 0xAAAA at 0xFFFFFFFF, then 0x5555 at 0x00000000.
REQ-024 Narrow load with bus_ready held low 3 cycles in RD_CAP -> bus_re and bus_addr stable throughout; resp_valid 3 cycles later than nominal, resp_err=0.
REQ-025 rst pulsed in the HI phase of a wide load -> next cycle IDLE, req_ready=1, no resp_valid; a following narrow load completes normally.
REQ-026 With MEM_BUS_TIMEOUT_EN defined and bus_ready stuck at 0 on a store -> resp_valid with resp_err=1 after 255 wait cycles; without the macro, no response after 1000 cycles.
